width_upsize_stream: RTL
========================

// Module: width_upsize_stream
// PURPOSE
//  Generic N:1 stream width upsizer with valid/ready handshake; successor to the fixed 8->16 converter.
//  Packs RATIO consecutive AWIDTH-bit input beats into one AWIDTH*RATIO-bit output word.
//  Supports early flush (a_last) of a partial word and full-rate backpressure.
//  Sits between narrow producers (byte/serial front ends) and wide datapath/FIFO stages.
// PARAMETERS
//  AWIDTH    8  input beat width, bits (>=1)
//  RATIO     2  beats per output word (>=2); BWIDTH = AWIDTH*RATIO (localparam)
//  MSB_FIRST 0  0: first beat -> lane 0 (b[AWIDTH-1:0]); 1: first beat -> lane RATIO-1 (MSBs)
// PORTS
//  clk     in   1              clock, rising edge
//  rst_n   in   1              asynchronous active-low reset
//  a_vld   in   1              input beat valid
//  a_rdy   out  1              input ready; beat accepted when a_vld & a_rdy
//  a       in   AWIDTH         input beat data
//  a_last  in   1              beat closes current word (sampled only on accept)
//  b_vld   out  1              output word valid
//  b_rdy   in   1              downstream ready; word consumed when b_vld & b_rdy
//  b       out  AWIDTH*RATIO   output word; unfilled lanes are zero
//  b_keep  out  RATIO          lane-valid mask, bit i = lane i (only with WIDTH_UPSIZE_KEEP_EN)
// BEHAVIOUR
//  - Async reset: b_vld=0, b=0, b_keep=0, lane count=0, accumulator=0; a_rdy=1 once released.
//  - Storage: accumulator (RATIO-1 lanes + lane count 0..RATIO-1) plus one output register.
//  - Lane index of the k-th accepted beat (k=0..RATIO-1): k if MSB_FIRST=0, RATIO-1-k otherwise.
//  - Completing beat: accepted beat with count==RATIO-1 or a_last=1. On that edge the accumulator
//    plus the current beat load the output register; b_vld=1 the next cycle (latency 1 clk after
//    the completing beat); count and accumulator clear.
//  - Non-completing beat: written to its lane, count+1; output register unaffected.
//  - a_rdy = !b_vld | b_rdy (combinational from b_rdy; no dependency on a_vld or a_last).
//  - Output register: holds b/b_keep stable while b_vld & !b_rdy; clears b_vld on consume unless a
//    completing beat reloads it on the same edge (back-to-back words, no bubble).
//  - Throughput: one beat per clock sustained with b_rdy=1; a word every RATIO clocks.
//  - a_last on first beat of a word: single-lane word, other lanes zero.
//  - a_last ignored when a_vld & a_rdy is false. a_vld low mid-word: accumulator holds,
//    no timeout, no implicit flush.
//  - Stall: when b_vld & !b_rdy, a_rdy=0 and accumulator frozen, including mid-word.
//  - Reset mid-word or mid-stall: partial word and pending output discarded, no emission.
//  - a/a_last may change freely while a_vld=0 or a_rdy=0 (not sampled).
// CONFIGURATION
//  WIDTH_UPSIZE_KEEP_EN defined: b_keep port present. Bit i=1 iff lane i was written for
//    this word; full word gives all ones. Loaded and held with b; reset 0.
//  Undefined: no b_keep port, no keep register. Partial words are still emitted zero-padded;
//    the downstream cannot tell them from data zeros.
// TESTING (AWIDTH=8, RATIO=2, MSB_FIRST=0 unless stated; b_rdy=1 unless stated)
//  1. Beats 0x00,0x11 consecutive -> one cycle after 0x11 accept: b=0x1100, b_vld=1 for 1 clk, keep=2'b11.
//  2. Beats 0x22..0xCC back-to-back -> b=0x3322,0x5544,0x7766,0x9988,0xBBAA on consecutive-pair
//     cycles. 0xCC remains in accumulator with no output.
//  3. 0x11 (a_last=1) then 0x22,0x33 -> b=0x0011 keep=2'b01, then b=0x3322 keep=2'b11.
//  4. b_rdy=0 for 5 clks with word 0x1100 pending and beat 0x22 presented -> a_rdy=0 and b
//     held. After b_rdy=1: 0x22 accepted and next word correct, no loss or duplication.
//  5. RATIO=4, MSB_FIRST=1, beats 0xA1,0xB2,0xC3,0xD4 -> b=0xA1B2C3D4. Then 0xEE with
//     a_last -> b=0xEE000000, keep=4'b1000.
//  6. rst_n pulsed low after 1 of 2 beats and while b_vld & !b_rdy -> b_vld=0 immediately.
//     Next beats 0x55,0x66 -> b=0x6655 only.

Source files
------------

// File: rtl/width_upsize_stream.sv
// N:1 stream width upsizer: packs RATIO AWIDTH-bit beats into one output word, with early flush via a_last.
// Optional lane-valid mask output b_keep is built when WIDTH_UPSIZE_KEEP_EN is defined.
module width_upsize_stream #(
  parameter int unsigned AWIDTH    = 8,
  parameter int unsigned RATIO     = 2,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_vld,
  output logic                     a_rdy,
  input  logic [AWIDTH-1:0]        a,
  input  logic                     a_last,
  output logic                     b_vld,
  input  logic                     b_rdy,
  output logic [AWIDTH*RATIO-1:0]  b
`ifdef WIDTH_UPSIZE_KEEP_EN
  ,
  output logic [RATIO-1:0]         b_keep
`endif
);

  localparam int unsigned BWIDTH = AWIDTH * RATIO;
  localparam int unsigned CW     = $clog2(RATIO);

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_CNT = cnt_t'(RATIO - 1);

  // Accumulator is indexed by beat order; lane placement happens when the word is assembled.
  logic [AWIDTH-1:0] acc_q [RATIO-1];
  logic [AWIDTH-1:0] acc_d [RATIO-1];
  cnt_t              cnt_q, cnt_d;
  logic              b_vld_q, b_vld_d;
  logic [BWIDTH-1:0] b_q, b_d;
  logic [BWIDTH-1:0] word;
  logic              accept;
  logic              complete;
`ifdef WIDTH_UPSIZE_KEEP_EN
  logic [RATIO-1:0]  keep_q, keep_d, keep_w;
`endif

  function automatic int unsigned lane_of(input int unsigned k);
    return MSB_FIRST ? (RATIO - 1 - k) : k;
  endfunction

  assign a_rdy    = !b_vld_q | b_rdy;
  assign accept   = a_vld & a_rdy;
  assign complete = accept & (a_last | (cnt_q == LAST_CNT));

  // Stored beats plus the in-flight beat, zero in lanes not yet written.
  always_comb begin
    word = '0;
    for (int unsigned k = 0; k < RATIO - 1; k++) begin
      if (cnt_t'(k) < cnt_q) word[lane_of(k)*AWIDTH +: AWIDTH] = acc_q[k];
    end
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (cnt_t'(k) == cnt_q) word[lane_of(k)*AWIDTH +: AWIDTH] = a;
    end
  end

`ifdef WIDTH_UPSIZE_KEEP_EN
  always_comb begin
    keep_w = '0;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (cnt_t'(k) <= cnt_q) keep_w[lane_of(k)] = 1'b1;
    end
  end
`endif

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    b_vld_d = b_vld_q;
    b_d     = b_q;
`ifdef WIDTH_UPSIZE_KEEP_EN
    keep_d  = keep_q;
`endif
    if (complete) begin
      for (int unsigned k = 0; k < RATIO - 1; k++) acc_d[k] = '0;
      cnt_d   = '0;
      b_d     = word;
      b_vld_d = 1'b1;
`ifdef WIDTH_UPSIZE_KEEP_EN
      keep_d  = keep_w;
`endif
    end else begin
      if (accept) begin
        for (int unsigned k = 0; k < RATIO - 1; k++) begin
          if (cnt_t'(k) == cnt_q) acc_d[k] = a;
        end
        cnt_d = cnt_q + cnt_t'(1);
      end
      if (b_rdy) b_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < RATIO - 1; k++) acc_q[k] <= '0;
      cnt_q   <= '0;
      b_vld_q <= 1'b0;
      b_q     <= '0;
`ifdef WIDTH_UPSIZE_KEEP_EN
      keep_q  <= '0;
`endif
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      b_vld_q <= b_vld_d;
      b_q     <= b_d;
`ifdef WIDTH_UPSIZE_KEEP_EN
      keep_q  <= keep_d;
`endif
    end
  end

  assign b_vld = b_vld_q;
  assign b     = b_q;
`ifdef WIDTH_UPSIZE_KEEP_EN
  assign b_keep = keep_q;
`endif

endmodule
